// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (3-sample majority vote, parity/stop/break checks) feeding a show-ahead FIFO.
// Good frames are written one cycle after the last stop-bit vote; a write into a full FIFO is dropped and pulses overrun.
module uart_rx_fifo_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wr_vld,
    input  logic [W-1:0]            i_wr_dat,
    input  logic                    i_rd_rdy,
    output logic                    o_rd_vld,
    output logic [W-1:0]            o_rd_dat,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_wr_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_wr_drop;
    logic          w_empty;
    logic          w_full;
    logic          w_do_rd;
    logic          w_do_wr;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_do_rd = i_rd_rdy && !w_empty;
    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign w_do_wr = i_wr_vld && (!w_full || w_do_rd);

    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= i_wr_vld && w_full && !w_do_rd;
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_do_wr && !w_do_rd) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_do_rd && !w_do_wr) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    assign o_rd_vld  = !w_empty;
    assign o_rd_dat  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_wr_drop = r_wr_drop;
endmodule

module uart_rx_fifo #(
    parameter int SYS_CLK_FRE = 50_000_000,
    parameter int BPS         = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          uart_rxd,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic                          break_det
);
    localparam int DIV   = SYS_CLK_FRE / (BPS * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [OS_W-1:0]  OS_ONE   = OS_W'(1);
    localparam logic [OS_W-1:0]  T_S0     = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  T_S1     = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  T_S2     = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [OS_W-1:0]  T_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);
    localparam logic             PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_prev;
    logic [DIV_W-1:0]      r_div_cnt;
    logic [OS_W-1:0]       r_smp_cnt;
    logic                  r_s0;
    logic                  r_s1;
    logic [DATA_BITS-1:0]  r_shift;
    logic [BIT_W-1:0]      r_bit_idx;
    logic                  r_stop_idx;
    logic                  r_par_err;
    logic                  r_stop_bad;
    logic                  r_zero;
    logic                  r_wr;
    logic [DATA_BITS-1:0]  r_wr_dat;
    logic                  r_frame_err;
    logic                  r_parity_err;
    logic                  w_fall;
    logic                  w_tick;
    logic                  w_mid;
    logic                  w_end;
    logic                  w_maj;
    logic                  w_restart;
    logic                  w_wr;
    logic                  w_ferr;
    logic                  w_perr;
    logic                  w_stop_bad;

    assign w_fall = r_prev && !r_sync2;
    assign w_tick = (r_div_cnt == DIV_LAST);
    assign w_mid  = w_tick && (r_smp_cnt == T_S2);
    assign w_end  = w_tick && (r_smp_cnt == T_LAST);
    assign w_maj  = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_restart  = 1'b0;
        w_wr       = 1'b0;
        w_ferr     = 1'b0;
        w_perr     = 1'b0;
        w_stop_bad = r_stop_bad | ~w_maj;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_next    = S_START;
                    w_restart = 1'b1;
                end
            end
            S_START: begin
                if (w_mid && w_maj) begin
                    w_next = S_IDLE;
                end else if (w_end) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_end && (r_bit_idx == BIT_LAST)) begin
                    w_next = (PARITY != 0) ? S_PAR : S_STOP;
                end
            end
            S_PAR: begin
                if (w_end) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                // Decide on the last vote of the final stop bit so a back-to-back start edge is still caught.
                if (w_mid && (r_stop_idx == STOP_LAST)) begin
                    if (r_zero && !w_maj) begin
                        w_next    = S_BREAK;
                        w_ferr    = 1'b1;
                        w_restart = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                        w_ferr = w_stop_bad;
                        w_perr = r_par_err;
                        w_wr   = !w_stop_bad && !r_par_err;
                    end
                end
            end
            S_BREAK: begin
                if (!r_sync2) begin
                    w_restart = 1'b1;
                end else if (w_end) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_prev       <= 1'b1;
            r_div_cnt    <= '0;
            r_smp_cnt    <= '0;
            r_s0         <= 1'b0;
            r_s1         <= 1'b0;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_stop_idx   <= 1'b0;
            r_par_err    <= 1'b0;
            r_stop_bad   <= 1'b0;
            r_zero       <= 1'b0;
            r_wr         <= 1'b0;
            r_wr_dat     <= '0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_sync1      <= uart_rxd;
            r_sync2      <= r_sync1;
            r_prev       <= r_sync2;
            r_wr         <= w_wr;
            r_wr_dat     <= r_shift;
            r_frame_err  <= w_ferr;
            r_parity_err <= w_perr;

            if (w_restart) begin
                r_div_cnt <= '0;
                r_smp_cnt <= '0;
            end else if (w_tick) begin
                r_div_cnt <= '0;
                r_smp_cnt <= r_smp_cnt + OS_ONE;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_ONE;
            end

            if (w_tick && (r_smp_cnt == T_S0)) begin
                r_s0 <= r_sync2;
            end
            if (w_tick && (r_smp_cnt == T_S1)) begin
                r_s1 <= r_sync2;
            end

            if ((r_state == S_IDLE) && w_fall) begin
                r_bit_idx  <= '0;
                r_stop_idx <= 1'b0;
                r_par_err  <= 1'b0;
                r_stop_bad <= 1'b0;
                r_zero     <= 1'b1;
            end

            if (w_mid) begin
                case (r_state)
                    S_DATA: begin
                        r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                        r_zero  <= r_zero & ~w_maj;
                    end
                    S_PAR: begin
                        r_par_err <= (^r_shift) ^ w_maj ^ PAR_ODD;
                        r_zero    <= r_zero & ~w_maj;
                    end
                    S_STOP: begin
                        r_stop_bad <= r_stop_bad | ~w_maj;
                        r_zero     <= r_zero & ~w_maj;
                    end
                    default: ;
                endcase
            end

            if (w_end && (r_state == S_DATA)) begin
                r_bit_idx <= r_bit_idx + BIT_ONE;
            end
            if (w_end && (r_state == S_STOP)) begin
                r_stop_idx <= 1'b1;
            end
        end
    end

    uart_rx_fifo_buf #(
        .W     (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (sys_clk),
        .i_rst     (sys_rst),
        .i_wr_vld  (r_wr),
        .i_wr_dat  (r_wr_dat),
        .i_rd_rdy  (rd_en),
        .o_rd_vld  (rd_valid),
        .o_rd_dat  (rd_data),
        .o_count   (fifo_count),
        .o_wr_drop (overrun)
    );

    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign break_det  = (r_state == S_BREAK);
endmodule
